// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the I/D memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick, purely combinational; gnt bit 0 = I-cache, bit 1 = D-cache.
// Zero latency; a lone requester always wins, on contention the master not granted last wins.
module mem_arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (i_req && d_req) begin
      gnt = (last_grant == GNT_I) ? 2'b10 : 2'b01;
    end else if (d_req) begin
      gnt = 2'b10;
    end else if (i_req) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache, one transaction at a time.
// mem_* asserts the cycle after capture; master ready pulses the cycle after mem_ready; losers wait.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            state;
  grant_t            grant;
  grant_t            last_grant;
  logic              cap_read;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              i_rdy_q;
  logic              d_rdy_q;
  logic [1:0]        pick;

  mem_arb_rr_pick u_pick (
    .i_req      (i_mem_read | i_mem_write),
    .d_req      (d_mem_read | d_mem_write),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state      <= IDLE;
      grant      <= GNT_I;
      last_grant <= GNT_I;
      cap_read   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_data  <= '0;
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          // read+write together is served as a write
          if (pick[1]) begin
            grant     <= GNT_D;
            cap_write <= d_mem_write;
            cap_read  <= d_mem_read & ~d_mem_write;
            cap_addr  <= d_mem_addr;
            cap_wdata <= d_mem_wdata;
            state     <= BUSY;
          end else if (pick[0]) begin
            grant     <= GNT_I;
            cap_write <= i_mem_write;
            cap_read  <= i_mem_read & ~i_mem_write;
            cap_addr  <= i_mem_addr;
            cap_wdata <= i_mem_wdata;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            resp_data  <= mem_rdata;
            last_grant <= grant;
            i_rdy_q    <= (grant == GNT_I);
            d_rdy_q    <= (grant == GNT_D);
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read    = (state == BUSY) & cap_read & ~mem_ready;
  assign mem_write   = (state == BUSY) & cap_write & ~mem_ready;
  assign mem_addr    = cap_addr;
  assign mem_wdata   = cap_wdata;
  assign i_mem_rdata = resp_data;
  assign d_mem_rdata = resp_data;
  assign i_mem_ready = i_rdy_q;
  assign d_mem_ready = d_rdy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning the block address width in 16-byte units.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the block data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port proc_reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have i_mem_read/i_mem_write, input, 1 each: I-cache request levels, held until i_mem_ready.
REQ-006 SHALL have i_mem_addr, input, ADDR_W, and i_mem_wdata, input, DATA_W: I-cache request address and write data.
REQ-007 SHALL have i_mem_rdata, output, DATA_W, and i_mem_ready, output, 1: I-cache response data and one-cycle completion pulse.
REQ-008 SHALL have d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready, identical in direction and width to the i_ ports: D-cache port.
REQ-009 SHALL have mem_read/mem_write, output, 1, mem_addr, output, ADDR_W, and mem_wdata, output, DATA_W: the shared memory request.
REQ-010 SHALL have mem_rdata, input, DATA_W, and mem_ready, input, 1: the shared memory response; mem_ready is a one-cycle pulse.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY, and RESP.
REQ-012 IDLE: with any request pending, SHALL capture the winner's op, addr, and wdata into registers, record the winner in a grant flag, and go to BUSY next cycle; otherwise SHALL stay in IDLE.
REQ-013 Arbitration: with one requester, that requester SHALL win; with both, the master not granted last SHALL win (round-robin); last_grant resets to I, so D wins first contention.
REQ-014 A master asserting read and write together SHALL be served as a write.
REQ-015 BUSY: mem_read = captured_read & ~mem_ready and mem_write = captured_write & ~mem_ready; mem_addr and mem_wdata SHALL be held stable from the registers.
REQ-016 BUSY with mem_ready: SHALL capture mem_rdata into the response register, update last_grant, and go to RESP.
REQ-017 RESP: SHALL assert the granted master's *_mem_ready for exactly one cycle, hold the other ready low, and go to IDLE.
REQ-018 i_mem_rdata and d_mem_rdata SHALL both drive the response register continuously; only the ready pulse qualifies the data.
REQ-019 Latency: for a request first seen in IDLE at cycle t, mem_* SHALL assert at t+1; memory ready at cycle m SHALL give the master ready at m+1.
REQ-020 Requests raised during BUSY/RESP SHALL be ignored until IDLE, with no loss as masters hold their level.
REQ-021 The non-granted master SHALL see ready=0 until it is served.
REQ-022 After reset, while idle, mem_addr and mem_wdata SHALL hold their last captured values; mem_read and mem_write SHALL be 0 outside BUSY.

Reset
REQ-023 proc_reset SHALL immediately force IDLE, last_grant=I, all captured registers and the response register to 0, and all outputs to 0.
REQ-024 Reset during BUSY SHALL abandon the memory transaction; mem_read/mem_write SHALL drop in the same cycle and no ready pulse SHALL be issued.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE, BUSY, RESP), the grant encoding (GNT_I, GNT_D), and the ADDR_W/DATA_W defaults.
REQ-026 A single combinational sub-module mem_arb_rr_pick (two requests plus last_grant in, one-hot grant out) is natural; all sequential logic SHALL stay in mem_arbiter.

Verification
REQ-027 I-only read of addr 0x0000010 with memory ready 3 cycles after mem_read: mem_read at t+1; i_mem_ready at the cycle after mem_ready; i_mem_rdata equals the memory word; d_mem_ready stays 0.
REQ-028 I read 0x10 and D write 0x20 asserted in the same cycle after reset: D served first (mem_write, mem_addr=0x20), then I (mem_read, mem_addr=0x10).
REQ-029 Both masters continuously requesting for 4 transactions: grants alternate D, I, D, I.
REQ-030 D asserts write and read together (wdata=128'hA5...): a single mem_write issues with that data and no mem_read.
REQ-031 proc_reset asserted mid-BUSY: mem_read drops the same cycle, no *_mem_ready pulse, and the next request after release starts cleanly from IDLE.
REQ-032 D write-back followed by a refill read (cache miss with dirty victim): two separate transactions, each ending in one d_mem_ready pulse; mem_addr is stable throughout each BUSY.
